// File: rtl/bus_pkg.sv
// Shared types and address map for the bus arbiter.
// Holds the region enum, region boundaries and the arbiter state type.
package bus_pkg;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_CART,
        RGN_VRAM,
        RGN_WRAM,
        RGN_OAM,
        RGN_IO,
        RGN_HRAM,
        RGN_INT
    } region_e;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } arb_state_t;

    localparam logic [15:0] CART0_HI = 16'h7FFF;
    localparam logic [15:0] VRAM_LO  = 16'h8000;
    localparam logic [15:0] VRAM_HI  = 16'h9FFF;
    localparam logic [15:0] CART1_LO = 16'hA000;
    localparam logic [15:0] CART1_HI = 16'hBFFF;
    localparam logic [15:0] WRAM_LO  = 16'hC000;
    localparam logic [15:0] WRAM_HI  = 16'hFDFF;
    localparam logic [15:0] OAM_LO   = 16'hFE00;
    localparam logic [15:0] OAM_HI   = 16'hFE9F;
    localparam logic [15:0] IO_LO    = 16'hFF00;
    localparam logic [15:0] IO_HI    = 16'hFF7F;
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [15:0] IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] IE_ADDR  = 16'hFFFF;

    // Watchdog trips on the 255th consecutive stalled cycle.
    localparam logic [7:0] WD_LAST = 8'd254;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address-to-region decoder.
// Only the low 16 address bits participate in the map.
module bus_region_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o
);

    logic [15:0] a;

    assign a = 16'(addr_i);

    // Interrupt registers sit inside the IO/HRAM windows, so test them first.
    always_comb begin
        region_o = RGN_NONE;
        if (a == IF_ADDR || a == IE_ADDR)
            region_o = RGN_INT;
        else if (a <= CART0_HI)
            region_o = RGN_CART;
        else if (a >= VRAM_LO && a <= VRAM_HI)
            region_o = RGN_VRAM;
        else if (a >= CART1_LO && a <= CART1_HI)
            region_o = RGN_CART;
        else if (a >= WRAM_LO && a <= WRAM_HI)
            region_o = RGN_WRAM;
        else if (a >= OAM_LO && a <= OAM_HI)
            region_o = RGN_OAM;
        else if (a >= IO_LO && a <= IO_HI)
            region_o = RGN_IO;
        else if (a >= HRAM_LO && a <= HRAM_HI)
            region_o = RGN_HRAM;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-master bus arbiter with burst counting and PPU blocking.
// Optional stall watchdog enabled by BUS_ARB_WATCHDOG_EN.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int RR_MODE     = 0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
    input  logic [NUM_MASTERS*8-1:0]      burst_len,
    input  logic                          vram_block,
    input  logic                          oam_block,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [ADDR_W-1:0]             sel_addr,
    output logic                          cart_target,
    output logic                          vram_target,
    output logic                          wram_target,
    output logic                          oam_target,
    output logic                          hram_target,
    output logic                          io_target,
    output logic                          int_target,
    output logic                          stall,
    output logic [NUM_MASTERS-1:0]        done,
    output logic                          err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_vld;
    logic [7:0]             win_len;
    logic                   xfer;
    logic                   own_req;
    logic                   blocked;
    logic                   wd_trip;
    region_e                rgn;

    assign xfer     = (state_q == ST_XFER);
    assign own_req  = req[owner_q];
    assign sel_addr = xfer ? addr[owner_q*ADDR_W +: ADDR_W] : '0;
    assign grant    = grant_q;

    bus_region_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr_i   (sel_addr),
        .region_o (rgn)
    );

    assign blocked = xfer
                   && ((rgn == RGN_VRAM && vram_block)
                    || (rgn == RGN_OAM && oam_block));

    assign stall       = blocked;
    assign cart_target = xfer && rgn == RGN_CART;
    assign vram_target = xfer && rgn == RGN_VRAM && !vram_block;
    assign wram_target = xfer && rgn == RGN_WRAM;
    assign oam_target  = xfer && rgn == RGN_OAM && !oam_block;
    assign io_target   = xfer && rgn == RGN_IO;
    assign hram_target = xfer && rgn == RGN_HRAM;
    assign int_target  = xfer && rgn == RGN_INT;

    // Descending scan so the highest-priority candidate is written last.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        if (RR_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                j = (int'(ptr_q) + k) % NUM_MASTERS;
                if (req[j]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(j);
                end
            end
        end
    end

    assign win_len = burst_len[win_idx*8 +: 8];

`ifdef BUS_ARB_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;

    assign wd_trip = blocked && own_req && (wd_q == WD_LAST);
    assign wd_d    = (blocked && own_req) ? wd_q + 8'd1 : 8'd0;
    assign err_d   = err_q | wd_trip;
    assign err     = err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_XFER;
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    grant_d = NUM_MASTERS'(1) << win_idx;
                    cnt_d   = (win_len == 8'd0) ? 8'd1 : win_len;
                end
            end
            ST_XFER: begin
                if (!own_req || wd_trip) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (!blocked) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        done    = grant_q;
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

endmodule
